// File: rtl/bop_alert_ctrl.sv
// Alert controller for the buffer-overflow protection unit: edge-detects the
// detection flags, tracks load taint into JALR targets, and raises acked alerts.
module bop_alert_ctrl #(
  parameter int TAINT_WINDOW = 8,
  parameter int MAX_ALERTS   = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             illegal_load_i,
  input  logic             lb_crash_i,
  input  logic             load_in_range_i,
  input  logic [6:0]       load_reg_i,
  input  logic             commit_valid_i,
  input  logic [31:0]      commit_pc_i,
  input  logic             commit_is_jalr_i,
  input  logic [4:0]       commit_rs1_i,
  input  logic [4:0]       commit_rd_i,
  output logic             alert_req_o,
  output logic [1:0]       alert_cause_o,
  output logic [31:0]      alert_pc_o,
  input  logic             alert_ack_i,
  output logic [CNT_W-1:0] alert_count_o,
  output logic             halt_o
);

  localparam int TW_W = $clog2(TAINT_WINDOW + 1);
  localparam int IL = 0;
  localparam int LB = 1;
  localparam int TJ = 2;

  typedef enum logic [1:0] {IDLE, RAISE, LOCKED} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic             il_q, lb_q;
  logic [2:0]       pend_q, pend_d, clr_mask, ev;
  logic [2:0][31:0] epc_q, epc_d;
  logic [4:0]       taint_reg_q, taint_reg_d;
  logic [TW_W-1:0]  taint_cnt_q, taint_cnt_d;
  logic             taint_vld_q, taint_vld_d;
  logic             req_q, req_d;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             have_pend, taint_ok, tj_ev;
  logic [1:0]       pick_cause;
  logic [31:0]      pick_pc;
  logic [2:0]       pick_mask;

  // Event detection: rising edges of the sticky flags and tainted JALR commits
  assign taint_ok = load_in_range_i & (load_reg_i[6:5] == 2'b00) & (load_reg_i[4:0] != 5'd0);
  assign tj_ev    = en_i & commit_valid_i & commit_is_jalr_i & taint_vld_q &
                    (commit_rs1_i == taint_reg_q);
  assign ev[IL]   = en_i & illegal_load_i & ~il_q;
  assign ev[LB]   = en_i & lb_crash_i & ~lb_q;
  assign ev[TJ]   = tj_ev;

  assign cnt_inc   = sat_inc(cnt_q);
  assign have_pend = |pend_q;

  always_comb begin
    taint_reg_d = taint_reg_q;
    taint_cnt_d = taint_cnt_q;
    taint_vld_d = taint_vld_q;
    if (clear_i || !en_i) begin
      taint_vld_d = 1'b0;
    end else begin
      // The commit is judged against the old taint before a new one installs
      if (commit_valid_i && taint_vld_q) begin
        taint_cnt_d = taint_cnt_q - TW_W'(1);
        if (tj_ev || (taint_cnt_q == TW_W'(1)) ||
            (!commit_is_jalr_i && (commit_rd_i == taint_reg_q)))
          taint_vld_d = 1'b0;
      end
      if (taint_ok) begin
        taint_reg_d = load_reg_i[4:0];
        taint_cnt_d = TW_W'(TAINT_WINDOW);
        taint_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    pick_cause = 2'd0;
    pick_pc    = '0;
    pick_mask  = '0;
    if (pend_q[LB]) begin
      pick_cause = 2'd2;
      pick_pc    = epc_q[LB];
      pick_mask  = 3'b010;
    end else if (pend_q[IL]) begin
      pick_cause = 2'd1;
      pick_pc    = epc_q[IL];
      pick_mask  = 3'b001;
    end else if (pend_q[TJ]) begin
      pick_cause = 2'd3;
      pick_pc    = epc_q[TJ];
      pick_mask  = 3'b100;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    cause_d  = '0;
    pc_d     = '0;
    cnt_d    = cnt_q;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (have_pend) begin
          state_d  = RAISE;
          req_d    = 1'b1;
          cause_d  = pick_cause;
          pc_d     = pick_pc;
          clr_mask = pick_mask;
        end
      end
      RAISE: begin
        if (req_q) begin
          if (alert_ack_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(MAX_ALERTS)) state_d = LOCKED;
            else if (!have_pend)               state_d = IDLE;
          end else begin
            req_d   = 1'b1;
            cause_d = cause_q;
            pc_d    = pc_q;
          end
        end else if (have_pend) begin
          // One-cycle gap after an ack, then the next pending cause goes out
          req_d    = 1'b1;
          cause_d  = pick_cause;
          pc_d     = pick_pc;
          clr_mask = pick_mask;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      req_d   = 1'b0;
      cause_d = '0;
      pc_d    = '0;
      cnt_d   = '0;
    end
  end

  // A cause already pending keeps its first PC unless it is being raised now
  always_comb begin
    pend_d = (pend_q & ~clr_mask) | ev;
    epc_d  = epc_q;
    for (int i = 0; i < 3; i++) begin
      if (ev[i] && (!pend_q[i] || clr_mask[i])) epc_d[i] = commit_pc_i;
    end
    if (clear_i) pend_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      il_q        <= 1'b0;
      lb_q        <= 1'b0;
      pend_q      <= '0;
      epc_q       <= '0;
      taint_reg_q <= '0;
      taint_cnt_q <= '0;
      taint_vld_q <= 1'b0;
      req_q       <= 1'b0;
      cause_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      il_q        <= illegal_load_i;
      lb_q        <= lb_crash_i;
      pend_q      <= pend_d;
      epc_q       <= epc_d;
      taint_reg_q <= taint_reg_d;
      taint_cnt_q <= taint_cnt_d;
      taint_vld_q <= taint_vld_d;
      req_q       <= req_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alert_req_o   = req_q;
  assign alert_cause_o = cause_q;
  assign alert_pc_o    = pc_q;
  assign alert_count_o = cnt_q;
  assign halt_o        = (state_q == LOCKED);

endmodule

// File: tb/tb_bop_alert_ctrl.sv
// Self-checking bench for bop_alert_ctrl: scenario tasks with a queue of
// expected (cause, pc) alerts popped as the DUT raises requests.
module tb_bop_alert_ctrl;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             en_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             illegal_load_i = 1'b0;
  logic             lb_crash_i = 1'b0;
  logic             load_in_range_i = 1'b0;
  logic [6:0]       load_reg_i = '0;
  logic             commit_valid_i = 1'b0;
  logic [31:0]      commit_pc_i = '0;
  logic             commit_is_jalr_i = 1'b0;
  logic [4:0]       commit_rs1_i = '0;
  logic [4:0]       commit_rd_i = '0;
  logic             alert_req_o;
  logic [1:0]       alert_cause_o;
  logic [31:0]      alert_pc_o;
  logic             alert_ack_i = 1'b0;
  logic [CNT_W-1:0] alert_count_o;
  logic             halt_o;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bop_alert_ctrl #(.TAINT_WINDOW(8), .MAX_ALERTS(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
    .illegal_load_i(illegal_load_i), .lb_crash_i(lb_crash_i),
    .load_in_range_i(load_in_range_i), .load_reg_i(load_reg_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_is_jalr_i(commit_is_jalr_i), .commit_rs1_i(commit_rs1_i),
    .commit_rd_i(commit_rd_i), .alert_req_o(alert_req_o),
    .alert_cause_o(alert_cause_o), .alert_pc_o(alert_pc_o),
    .alert_ack_i(alert_ack_i), .alert_count_o(alert_count_o), .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  task automatic do_ack();
    alert_ack_i = 1'b1;
    cyc();
    alert_ack_i = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (alert_req_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic commit_plain(input int n);
    commit_valid_i = 1'b1; commit_is_jalr_i = 1'b0; commit_rd_i = 5'd0;
    repeat (n) cyc();
    commit_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    n_cmp++;
    if ({alert_req_o, alert_cause_o, alert_pc_o, alert_count_o, halt_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b cause=%0d pc=%h cnt=%0d halt=%b, want all 0",
               alert_req_o, alert_cause_o, alert_pc_o, alert_count_o, halt_o);
    end
    rst_i = 1'b0;
    en_i  = 1'b1;
    cyc();
  endtask

  task automatic test_lb_crash();
    exp_t e;
    bit   seen;
    do_clear();
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_0100;
    exp_q.push_back('{2'd2, 32'h8000_0100});
    cyc();
    commit_pc_i = '0;
    n_cmp++;
    if (alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL lb_early: req=%b, want 0 one cycle after edge", alert_req_o);
    end
    cyc();
    n_cmp++;
    if (alert_req_o !== 1'b1) begin
      n_bad++; $display("FAIL lb_latency: req=%b, want 1 two cycles after edge", alert_req_o);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
        n_bad++; $display("FAIL lb_payload: cause=%0d pc=%h, want cause=%0d pc=%h",
                          alert_cause_o, alert_pc_o, e.cause, e.pc);
      end
    end
    repeat (3) cyc();
    n_cmp++;
    if (alert_req_o !== 1'b1 || alert_cause_o !== 2'd2 || alert_pc_o !== 32'h8000_0100) begin
      n_bad++; $display("FAIL lb_hold: req=%b cause=%0d pc=%h, want 1/2/80000100",
                        alert_req_o, alert_cause_o, alert_pc_o);
    end
    do_ack();
    n_cmp++;
    if (alert_count_o !== 4'd1 || alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL lb_ack: cnt=%0d req=%b, want cnt=1 req=0", alert_count_o, alert_req_o);
    end
    seen = 1'b0;
    repeat (5) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL lb_refire: saw req=1 with level held, want none");
    end
    lb_crash_i = 1'b0;
    cyc();
  endtask

  task automatic test_taint_jump();
    exp_t e;
    bit   ok, seen;
    // 3 commits then JALR, and the 8th-commit boundary (7 then JALR): both alert
    for (int t = 0; t < 2; t++) begin
      do_clear();
      load_in_range_i = 1'b1; load_reg_i = 7'd5;
      cyc();
      load_in_range_i = 1'b0;
      commit_plain(t == 0 ? 3 : 7);
      commit_valid_i = 1'b1; commit_is_jalr_i = 1'b1; commit_rs1_i = 5'd5;
      commit_rd_i = 5'd1; commit_pc_i = 32'h8000_0200 + 32'(t * 16);
      exp_q.push_back('{2'd3, 32'h8000_0200 + 32'(t * 16)});
      cyc();
      commit_valid_i = 1'b0; commit_is_jalr_i = 1'b0; commit_pc_i = '0;
      wait_req(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL taint_req%0d: req=%b, want 1", t, alert_req_o);
      end
      if (ok && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
          n_bad++; $display("FAIL taint_payload%0d: cause=%0d pc=%h, want cause=%0d pc=%h",
                            t, alert_cause_o, alert_pc_o, e.cause, e.pc);
        end
      end
      do_ack();
    end
    // 8 intervening commits: the taint has expired
    load_in_range_i = 1'b1; load_reg_i = 7'd5;
    cyc();
    load_in_range_i = 1'b0;
    commit_plain(8);
    commit_valid_i = 1'b1; commit_is_jalr_i = 1'b1; commit_rs1_i = 5'd5;
    cyc();
    commit_valid_i = 1'b0; commit_is_jalr_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL taint_expired: saw req=1, want none after 8 commits");
    end
  endtask

  task automatic test_taint_kill();
    bit seen;
    do_clear();
    // taint reg 5, overwrite rd=5, then JALR rs1=5; then an ignored reg-field value
    for (int t = 0; t < 2; t++) begin
      load_in_range_i = 1'b1; load_reg_i = (t == 0) ? 7'd5 : 7'h25;
      cyc();
      load_in_range_i = 1'b0;
      if (t == 0) begin
        commit_valid_i = 1'b1; commit_is_jalr_i = 1'b0; commit_rd_i = 5'd5;
        cyc();
      end
      commit_valid_i = 1'b1; commit_is_jalr_i = 1'b1; commit_rs1_i = 5'd5; commit_rd_i = 5'd0;
      cyc();
      commit_valid_i = 1'b0; commit_is_jalr_i = 1'b0;
      seen = 1'b0;
      repeat (4) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
      n_cmp++;
      if (seen) begin
        n_bad++; $display("FAIL taint_kill%0d: saw req=1, want none", t);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    bit   ok;
    do_clear();
    illegal_load_i = 1'b1; lb_crash_i = 1'b1; commit_pc_i = 32'h8000_0300;
    exp_q.push_back('{2'd2, 32'h8000_0300});
    exp_q.push_back('{2'd1, 32'h8000_0300});
    cyc();
    commit_pc_i = '0;
    wait_req(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin
      n_bad++; $display("FAIL prio_first_req: req=%b, want 1", alert_req_o);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
        n_bad++; $display("FAIL prio_first: cause=%0d pc=%h, want cause=%0d pc=%h",
                          alert_cause_o, alert_pc_o, e.cause, e.pc);
      end
    end
    do_ack();
    n_cmp++;
    if (alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL prio_gap: req=%b, want 0 for one cycle", alert_req_o);
    end
    cyc();
    n_cmp++;
    if (alert_req_o !== 1'b1 || exp_q.size() == 0) begin
      n_bad++; $display("FAIL prio_second_req: req=%b, want 1", alert_req_o);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
        n_bad++; $display("FAIL prio_second: cause=%0d pc=%h, want cause=%0d pc=%h",
                          alert_cause_o, alert_pc_o, e.cause, e.pc);
      end
    end
    do_ack();
    n_cmp++;
    if (alert_count_o !== 4'd2) begin
      n_bad++; $display("FAIL prio_count: cnt=%0d, want 2", alert_count_o);
    end
    illegal_load_i = 1'b0; lb_crash_i = 1'b0;
    cyc();
  endtask

  task automatic test_lock();
    exp_t e;
    bit   ok, seen;
    do_clear();
    for (int k = 0; k < 4; k++) begin
      lb_crash_i = 1'b1; commit_pc_i = 32'h8000_1000 + 32'(k * 4);
      exp_q.push_back('{2'd2, 32'h8000_1000 + 32'(k * 4)});
      cyc();
      lb_crash_i = 1'b0; commit_pc_i = '0;
      wait_req(ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
        n_bad++; $display("FAIL lock_req%0d: req=%b, want 1", k, alert_req_o);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
          n_bad++; $display("FAIL lock_payload%0d: cause=%0d pc=%h, want cause=%0d pc=%h",
                            k, alert_cause_o, alert_pc_o, e.cause, e.pc);
        end
      end
      do_ack();
    end
    n_cmp++;
    if (halt_o !== 1'b1 || alert_count_o !== 4'd4 || alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL lock_enter: halt=%b cnt=%0d req=%b, want 1/4/0",
                        halt_o, alert_count_o, alert_req_o);
    end
    illegal_load_i = 1'b1;
    seen = 1'b0;
    repeat (5) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen || halt_o !== 1'b1) begin
      n_bad++; $display("FAIL lock_hold: seen_req=%b halt=%b, want 0/1", seen, halt_o);
    end
    do_clear();
    n_cmp++;
    if (halt_o !== 1'b0 || alert_count_o !== 4'd0 || alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL lock_clear: halt=%b cnt=%0d req=%b, want 0/0/0",
                        halt_o, alert_count_o, alert_req_o);
    end
    seen = 1'b0;
    repeat (4) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL clear_refire: saw req=1 after clear, want none");
    end
    illegal_load_i = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    do_clear();
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_4000;
    exp_q.push_back('{2'd2, 32'h8000_4000});
    cyc();
    illegal_load_i = 1'b1; commit_pc_i = 32'h8000_4100;
    cyc();
    illegal_load_i = 1'b0; lb_crash_i = 1'b0;
    cyc();
    illegal_load_i = 1'b1; commit_pc_i = 32'h8000_4200;
    cyc();
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_4300;
    exp_q.push_back('{2'd2, 32'h8000_4300});
    exp_q.push_back('{2'd1, 32'h8000_4100});
    cyc();
    illegal_load_i = 1'b0; lb_crash_i = 1'b0; commit_pc_i = '0;
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_req%0d: req=%b, want 1", k, alert_req_o);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
          n_bad++; $display("FAIL b2b_payload%0d: cause=%0d pc=%h, want cause=%0d pc=%h",
                            k, alert_cause_o, alert_pc_o, e.cause, e.pc);
        end
      end
      do_ack();
    end
    n_cmp++;
    if (alert_count_o !== 4'd3) begin
      n_bad++; $display("FAIL b2b_count: cnt=%0d, want 3", alert_count_o);
    end
    // stray acks with no request outstanding change nothing
    alert_ack_i = 1'b1;
    repeat (3) cyc();
    alert_ack_i = 1'b0;
    n_cmp++;
    if (alert_count_o !== 4'd3 || alert_req_o !== 1'b0) begin
      n_bad++; $display("FAIL stray_ack: cnt=%0d req=%b, want 3/0", alert_count_o, alert_req_o);
    end
  endtask

  task automatic test_clear_ack();
    exp_t e;
    bit   ok;
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_5000;
    exp_q.push_back('{2'd2, 32'h8000_5000});
    cyc();
    lb_crash_i = 1'b0; commit_pc_i = '0;
    wait_req(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin
      n_bad++; $display("FAIL clrack_req: req=%b, want 1", alert_req_o);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (alert_cause_o !== e.cause || alert_pc_o !== e.pc) begin
        n_bad++; $display("FAIL clrack_payload: cause=%0d pc=%h, want cause=%0d pc=%h",
                          alert_cause_o, alert_pc_o, e.cause, e.pc);
      end
    end
    clear_i = 1'b1; alert_ack_i = 1'b1;
    cyc();
    clear_i = 1'b0; alert_ack_i = 1'b0;
    n_cmp++;
    if (alert_count_o !== 4'd0 || alert_req_o !== 1'b0 || halt_o !== 1'b0) begin
      n_bad++; $display("FAIL clear_vs_ack: cnt=%0d req=%b halt=%b, want 0/0/0",
                        alert_count_o, alert_req_o, halt_o);
    end
  endtask

  task automatic test_enable();
    exp_t e;
    bit   ok, seen;
    en_i = 1'b0;
    lb_crash_i = 1'b1;
    cyc();
    lb_crash_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin cyc(); if (alert_req_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL en_off_event: saw req=1 with en=0, want none");
    end
    en_i = 1'b1;
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_6000;
    exp_q.push_back('{2'd2, 32'h8000_6000});
    cyc();
    lb_crash_i = 1'b0; commit_pc_i = '0;
    wait_req(ok);
    if (ok && exp_q.size() > 0) e = exp_q.pop_front();
    en_i = 1'b0;
    repeat (2) cyc();
    n_cmp++;
    if (alert_req_o !== 1'b1 || alert_pc_o !== 32'h8000_6000) begin
      n_bad++; $display("FAIL en_off_outstanding: req=%b pc=%h, want 1/80006000",
                        alert_req_o, alert_pc_o);
    end
    do_ack();
    n_cmp++;
    if (alert_count_o !== 4'd1) begin
      n_bad++; $display("FAIL en_off_ack: cnt=%0d, want 1", alert_count_o);
    end
    en_i = 1'b1;
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   ok, seen;
    lb_crash_i = 1'b1; commit_pc_i = 32'h8000_7000;
    exp_q.push_back('{2'd2, 32'h8000_7000});
    cyc();
    lb_crash_i = 1'b0; commit_pc_i = '0;
    wait_req(ok);
    if (ok && exp_q.size() > 0) e = exp_q.pop_front();
    #2;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({alert_req_o, alert_cause_o, alert_pc_o, alert_count_o, halt_o} !== '0) begin
      n_bad++; $display("FAIL async_reset: req=%b cause=%0d pc=%h cnt=%0d halt=%b, want all 0",
                        alert_req_o, alert_cause_o, alert_pc_o, alert_count_o, halt_o);
    end
    cyc();
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin cyc(); if (alert_req_o !== 1'b0 || halt_o !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL post_reset_idle: saw req or halt after release, want none");
    end
  endtask

  initial begin
    test_reset();
    test_lb_crash();
    test_taint_jump();
    test_taint_kill();
    test_priority();
    test_lock();
    test_back_to_back();
    test_clear_ack();
    test_enable();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d alerts never raised, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
